// File: rtl/fpadd_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fpadd_pkg : shared constants and FSM encoding for the fpadd scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
package fpadd_pkg;

  localparam int c_word_w      = 32;
  localparam int c_nreq_def    = 4;
  localparam int c_timeout_def = 63;
  localparam int c_cnt_w       = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter : picks the lowest requesting index at or above ptr, wrapping
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_pos;

  // Scan in rotated order; the first hit wins, later hits are masked by valid.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    w_sum = '0;
    w_pos = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NREQ)) begin
        w_sum = w_sum - (IW+1)'(NREQ);
      end
      w_pos = w_sum[IW-1:0];
      if (!valid && req[w_pos]) begin
        valid        = 1'b1;
        grant[w_pos] = 1'b1;
        idx          = w_pos;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpadd_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fpadd_sched : round-robin scheduler sharing one fp adder among NREQ clients
// Rev 1.0
// ----------------------------------------------------------------------------
module fpadd_sched
  import fpadd_pkg::*;
#(
  parameter int NREQ    = c_nreq_def,
  parameter int TIMEOUT = c_timeout_def
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*c_word_w-1:0]   op_a,
  input  logic [NREQ*c_word_w-1:0]   op_b,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [c_word_w-1:0]        rsp_sum,
  output logic                       rsp_err,
  output logic                       busy,
  output logic                       fa_start,
  output logic [c_word_w-1:0]        fa_a,
  output logic [c_word_w-1:0]        fa_b,
  input  logic [c_word_w-1:0]        fa_sum,
  input  logic                       fa_done
);

  localparam int                 c_iw       = $clog2(NREQ);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

  state_t              r_state;
  logic [c_iw-1:0]     r_ptr;
  logic [c_iw-1:0]     r_grantee;
  logic [c_cnt_w-1:0]  r_cnt;

  logic [NREQ-1:0]     w_grant;
  logic [c_iw-1:0]     w_idx;
  logic                w_any;
  logic [NREQ-1:0]     w_rsp_onehot;
  logic [c_iw-1:0]     w_ptr_next;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (c_iw)
  ) u_arb (
    .req   (req),
    .ptr   (r_ptr),
    .grant (w_grant),
    .idx   (w_idx),
    .valid (w_any)
  );

  assign w_rsp_onehot = NREQ'(1) << r_grantee;
  assign w_ptr_next   = (r_grantee == c_iw'(NREQ - 1)) ? '0 : r_grantee + c_iw'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_grantee <= '0;
      r_cnt     <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      fa_start  <= 1'b0;
      rsp_sum   <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      fa_a      <= '0;
      fa_b      <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      fa_start  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // gnt/fa_start are set here so they appear as registered pulses in ISSUE.
          if (w_any) begin
            fa_a      <= op_a[c_word_w*w_idx +: c_word_w];
            fa_b      <= op_b[c_word_w*w_idx +: c_word_w];
            r_grantee <= w_idx;
            gnt       <= w_grant;
            fa_start  <= 1'b1;
            busy      <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // fa_done is deliberately ignored here: it may still hold the previous result.
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (fa_done) begin
            rsp_sum   <= fa_sum;
            rsp_err   <= 1'b0;
            rsp_valid <= w_rsp_onehot;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
            if (r_cnt == c_cnt_last) begin
              rsp_sum   <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= w_rsp_onehot;
              r_state   <= S_RESP;
            end
          end
        end
        S_RESP: begin
          r_ptr   <= w_ptr_next;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpadd_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fpadd_sched : directed + random bench with a transaction-level model
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fpadd_sched;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 63;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*32-1:0]   op_a, op_b;
  logic [NREQ-1:0]      gnt, rsp_valid;
  logic [31:0]          rsp_sum, fa_a, fa_b, fa_sum;
  logic                 rsp_err, busy, fa_start, fa_done;
  logic                 ad_done, stale_done;

  assign fa_done = ad_done | stale_done;

  always #5 clk = ~clk;

  fpadd_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .fa_start  (fa_start),
    .fa_a      (fa_a),
    .fa_b      (fa_b),
    .fa_sum    (fa_sum),
    .fa_done   (fa_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int start_cnt = 0;
  int add_lat = 4;
  bit add_never = 1'b0;
  bit hold_req  = 1'b0;

  int          gnt_idx_q[$];
  int          gnt_cyc_q[$];
  int          rsp_idx_q[$];
  int          rsp_cyc_q[$];
  logic [31:0] rsp_sum_q[$];
  bit          rsp_err_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Stand-in adder result: exact for 1.0+2.0, an operand hash otherwise.
  function automatic logic [31:0] fake_add(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A0001;
  endfunction

  function automatic int rr_pick(input int p, input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int oh2idx(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) if (v[k]) return k;
    return -1;
  endfunction

  // Adder model: clears done on start, raises done with the result add_lat edges later.
  initial begin : adder
    bit st, rs;
    int lat, left;
    logic [31:0] pa, pb, pend;
    ad_done = 1'b0; fa_sum = '0; left = 0; pend = '0;
    forever begin
      @(negedge clk);
      st = fa_start; rs = reset; pa = fa_a; pb = fa_b; lat = add_lat;
      @(posedge clk); #1;
      if (!rs) begin
        ad_done = 1'b0; left = 0;
      end else if (st) begin
        ad_done = 1'b0; left = lat; pend = fake_add(pa, pb);
      end else if (left > 0) begin
        left--;
        if (left == 0 && !add_never) begin
          ad_done = 1'b1; fa_sum = pend;
        end
      end
    end
  end

  // Compare process: transaction model advanced once per cycle from sampled inputs.
  initial begin : cmp
    int mode, who, waited, ptr, p;
    logic [31:0] cap_a, cap_b, res;
    bit err;
    logic [NREQ-1:0] eg, er;
    mode = 0; who = 0; waited = 0; ptr = 0; cap_a = '0; cap_b = '0; res = '0; err = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (gnt != '0) begin gnt_idx_q.push_back(oh2idx(gnt)); gnt_cyc_q.push_back(cyc); end
      if (fa_start) start_cnt++;
      if (rsp_valid != '0) begin
        rsp_idx_q.push_back(oh2idx(rsp_valid)); rsp_cyc_q.push_back(cyc);
        rsp_sum_q.push_back(rsp_sum); rsp_err_q.push_back(rsp_err);
      end
      if (!reset) begin
        mode = 0; ptr = 0; cap_a = '0; cap_b = '0;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_fa_start", 32'(fa_start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_fa_a", fa_a, 0);
        chk("rst_fa_b", fa_b, 0);
      end else begin
        eg = (mode == 1) ? NREQ'(1) << who : '0;
        er = (mode == 3) ? NREQ'(1) << who : '0;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("fa_start", 32'(fa_start), 32'(mode == 1));
        chk("rsp_valid", 32'(rsp_valid), 32'(er));
        chk("busy", 32'(busy), 32'(mode != 0));
        chk("fa_a", fa_a, cap_a);
        chk("fa_b", fa_b, cap_b);
        if (mode == 3) begin
          chk("rsp_sum", rsp_sum, res);
          chk("rsp_err", 32'(rsp_err), 32'(err));
        end
        case (mode)
          0: begin
            p = rr_pick(ptr, req);
            if (p >= 0) begin
              who = p; cap_a = op_a[32*p +: 32]; cap_b = op_b[32*p +: 32]; mode = 1;
            end
          end
          1: begin waited = 0; mode = 2; end
          2: begin
            if (fa_done) begin
              res = fa_sum; err = 1'b0; mode = 3;
            end else begin
              waited++;
              if (waited >= TIMEOUT) begin res = '0; err = 1'b1; mode = 3; end
            end
          end
          default: begin ptr = (who + 1) % NREQ; mode = 0; end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (!hold_req) req = req & ~gnt;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req[i] = 1'b1;
    op_a[32*i +: 32] = a;
    op_b[32*i +: 32] = b;
  endtask

  task automatic wait_gnt(input int n, input int budget, input string name);
    int b = 0;
    while (gnt_idx_q.size() < n && b < budget) begin tick(); b++; end
    chk(name, 32'(gnt_idx_q.size() >= n), 1);
  endtask

  task automatic wait_rsp(input int n, input int budget, input string name);
    int b = 0;
    while (rsp_idx_q.size() < n && b < budget) begin tick(); b++; end
    chk(name, 32'(rsp_idx_q.size() >= n), 1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int g0, r0, s0;
    int exp_seq[5];
    logic [31:0] ta, tb;
    exp_seq = '{0, 1, 2, 3, 0};
    reset = 1'b0; req = '0; op_a = '0; op_b = '0; stale_done = 1'b0;
    repeat (3) tick();
    reset = 1'b1;

    // Single request, 1.0 + 2.0, adder latency 30
    add_lat = 30;
    g0 = gnt_idx_q.size(); r0 = rsp_idx_q.size(); s0 = start_cnt;
    set_req(0, 32'h3F800000, 32'h40000000);
    wait_gnt(g0 + 1, 10, "t_single_gnt_wait");
    wait_rsp(r0 + 1, 60, "t_single_rsp_wait");
    tick();
    chk("t_single_starts", 32'(start_cnt - s0), 1);
    if (rsp_idx_q.size() > r0 && gnt_idx_q.size() > g0) begin
      chk("t_single_gnt_idx", 32'(gnt_idx_q[g0]), 0);
      chk("t_single_rsp_idx", 32'(rsp_idx_q[r0]), 0);
      chk("t_single_sum", rsp_sum_q[r0], 32'h40400000);
      chk("t_single_err", 32'(rsp_err_q[r0]), 0);
      chk("t_single_latency", 32'(rsp_cyc_q[r0] - gnt_cyc_q[g0]), 32);
    end

    // All four held from ptr 0: grants 0,1,2,3,0
    reset = 1'b0; tick(); tick(); reset = 1'b1;
    add_lat = 3; hold_req = 1'b1;
    g0 = gnt_idx_q.size(); r0 = rsp_idx_q.size();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i * 16 + 1), 32'(i * 16 + 2));
    wait_gnt(g0 + 5, 100, "t_rr_gnt_wait");
    req = '0; hold_req = 1'b0;
    wait_rsp(r0 + 5, 40, "t_rr_rsp_wait");
    for (int k = 0; k < 5; k++) begin
      if (gnt_idx_q.size() > g0 + k && rsp_idx_q.size() > r0 + k) begin
        chk($sformatf("t_rr_gnt%0d", k), 32'(gnt_idx_q[g0 + k]), 32'(exp_seq[k]));
        chk($sformatf("t_rr_rsp%0d", k), 32'(rsp_idx_q[r0 + k]), 32'(exp_seq[k]));
      end
    end

    // Adder never finishes: timeout response, then a normal one
    add_never = 1'b1;
    g0 = gnt_idx_q.size(); r0 = rsp_idx_q.size();
    set_req(1, 32'h11112222, 32'h33334444);
    wait_gnt(g0 + 1, 10, "t_to_gnt_wait");
    wait_rsp(r0 + 1, 100, "t_to_rsp_wait");
    if (rsp_idx_q.size() > r0 && gnt_idx_q.size() > g0) begin
      chk("t_to_idx", 32'(rsp_idx_q[r0]), 1);
      chk("t_to_sum", rsp_sum_q[r0], 32'h0);
      chk("t_to_err", 32'(rsp_err_q[r0]), 1);
      chk("t_to_latency", 32'(rsp_cyc_q[r0] - gnt_cyc_q[g0]), 64);
    end
    add_never = 1'b0; add_lat = 6;
    r0 = rsp_idx_q.size();
    set_req(2, 32'h3F800000, 32'h40000000);
    wait_rsp(r0 + 1, 40, "t_after_to_rsp_wait");
    if (rsp_idx_q.size() > r0) begin
      chk("t_after_to_idx", 32'(rsp_idx_q[r0]), 2);
      chk("t_after_to_sum", rsp_sum_q[r0], 32'h40400000);
      chk("t_after_to_err", 32'(rsp_err_q[r0]), 0);
    end

    // Pointer now 3: reset in WAIT must abandon the op and clear the pointer
    add_lat = 20;
    g0 = gnt_idx_q.size();
    set_req(3, 32'hAAAA0000, 32'h0000BBBB);
    wait_gnt(g0 + 1, 10, "t_rst_gnt_wait");
    repeat (4) tick();
    r0 = rsp_idx_q.size();
    reset = 1'b0;
    set_req(2, 32'h01020304, 32'h05060708);
    set_req(3, 32'h0A0B0C0D, 32'h0E0F1011);
    tick(); tick();
    reset = 1'b1;
    add_lat = 2;
    g0 = gnt_idx_q.size();
    wait_gnt(g0 + 1, 10, "t_rst_regnt_wait");
    wait_rsp(r0 + 2, 40, "t_rst_rsp_wait");
    if (gnt_idx_q.size() > g0 && rsp_idx_q.size() > r0 + 1) begin
      chk("t_rst_first_gnt", 32'(gnt_idx_q[g0]), 2);
      chk("t_rst_first_rsp", 32'(rsp_idx_q[r0]), 2);
      chk("t_rst_second_rsp", 32'(rsp_idx_q[r0 + 1]), 3);
    end

    // Stale done held through ISSUE, dropped in the first WAIT cycle
    stale_done = 1'b1; add_lat = 5;
    g0 = gnt_idx_q.size(); r0 = rsp_idx_q.size();
    set_req(0, 32'h3F800000, 32'h40000000);
    wait_gnt(g0 + 1, 10, "t_stale_gnt_wait");
    stale_done = 1'b0;
    wait_rsp(r0 + 1, 30, "t_stale_rsp_wait");
    if (rsp_idx_q.size() > r0 && gnt_idx_q.size() > g0) begin
      chk("t_stale_sum", rsp_sum_q[r0], 32'h40400000);
      chk("t_stale_latency", 32'(rsp_cyc_q[r0] - gnt_cyc_q[g0]), 7);
    end

    // Request dropped during ISSUE still gets its response
    add_lat = 4;
    r0 = rsp_idx_q.size();
    ta = 32'h12345678; tb = 32'h9ABCDEF0;
    set_req(1, ta, tb);
    wait_rsp(r0 + 1, 30, "t_drop_rsp_wait");
    if (rsp_idx_q.size() > r0) begin
      chk("t_drop_idx", 32'(rsp_idx_q[r0]), 1);
      chk("t_drop_sum", rsp_sum_q[r0], fake_add(ta, tb));
    end

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c % 50 == 0) begin
        add_lat   = $urandom_range(1, 12);
        add_never = ($urandom_range(0, 7) == 0);
      end
      if (c == 1500) begin reset = 1'b0; req = '0; end
      if (c == 1503) reset = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (reset && !req[i] && $urandom_range(0, 3) == 0) set_req(i, $urandom, $urandom);
      end
    end
    req = '0; add_never = 1'b0;
    repeat (150) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpadd_sched.md
FPADD_SCHED -- requirements
Module: fpadd_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one fpadd instance (2..8).
REQ-002 Parameter TIMEOUT, default 63, max cycles waited for fa_done (1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  NREQ  per-requester request level.
REQ-006 op_a  input  NREQ*32  requester i operand A at bits [32i+31:32i], IEEE-754 single.
REQ-007 op_b  input  NREQ*32  requester i operand B, same packing.
REQ-008 gnt  output  NREQ  one-hot one-cycle pulse: operands of that requester captured.
REQ-009 rsp_valid  output  NREQ  one-hot one-cycle pulse: result for that requester.
REQ-010 rsp_sum  output  32  result word, valid while rsp_valid nonzero.
REQ-011 rsp_err  output  1  timeout flag, valid while rsp_valid nonzero.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 fa_start  output  1  start pulse to adder.
REQ-014 fa_a, fa_b  output  32 each  operands to adder.
REQ-015 fa_sum  input  32  adder result.
REQ-016 fa_done  input  1  adder completion level (adder clears it on start).

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, RESP; registered state, registered outputs.
REQ-018 IDLE: if req nonzero, round-robin pick from pointer ptr (lowest index >= ptr, wrapping), capture op_a/op_b slice into fa_a/fa_b, record grantee, go ISSUE; else stay.
REQ-019 ISSUE (exactly one cycle): fa_start=1, gnt[grantee]=1, wait counter cleared, go WAIT.
REQ-020 WAIT: fa_done=1 -> capture fa_sum, err=0, go RESP; else counter increments; counter reaching TIMEOUT -> rsp_sum value 0, err=1, go RESP.
REQ-021 fa_done sampled only in WAIT; never in ISSUE (stale done ignored).
REQ-022 RESP (one cycle): rsp_valid[grantee]=1, rsp_sum, rsp_err driven; ptr <= (grantee+1) mod NREQ; go IDLE.
REQ-023 Latency: req seen in IDLE -> gnt next cycle; rsp_valid = 1 cycle after fa_done observed in WAIT.
REQ-024 fa_a/fa_b held stable from ISSUE through RESP; change only on IDLE capture.
REQ-025 Requester holds req and operands until its gnt; req dropped after capture does not cancel; response still delivered.
REQ-026 Requests arriving while busy wait; no queueing beyond req level; no request starves (max wait NREQ-1 operations).
REQ-027 Back-to-back: new capture possible in IDLE cycle following RESP; minimum issue interval 4 cycles plus adder latency.
REQ-028 gnt, rsp_valid, fa_start zero in all cycles not stated above.
REQ-029 Counter 8 bits, no wrap (TIMEOUT <= 255).

Reset
REQ-030 reset low: state IDLE, ptr 0, gnt/rsp_valid/fa_start 0, rsp_sum/fa_a/fa_b 0, rsp_err 0, busy 0, counter 0, immediately.
REQ-031 Reset mid-operation abandons the operation silently; no rsp_valid issued for it.
REQ-032 First request accepted on first rising edge after reset deasserts.

Structure
REQ-033 Shared package fpadd_pkg holds FSM state encoding, word width 32, NREQ/TIMEOUT defaults.
REQ-034 Round-robin selection in sub-module rr_arbiter (inputs req, ptr; output one-hot grant and index).

Verification
REQ-035 Single req[0], a=0x3F800000, b=0x40000000, model adder done after 30 cycles -> gnt[0] pulse, fa_start one pulse, rsp_valid[0] with rsp_sum=0x40400000, rsp_err=0.
REQ-036 req=4'b1111 held, ptr=0 -> grants in order 0,1,2,3,0; each rsp_valid index matches preceding gnt.
REQ-037 Adder never asserts done, TIMEOUT=63 -> rsp_valid after 63 WAIT cycles, rsp_sum=0, rsp_err=1, next request served normally.
REQ-038 Stale fa_done=1 held across ISSUE, dropped next cycle -> not accepted; result taken only on later done.
REQ-039 reset low during WAIT -> all outputs 0 same cycle, no rsp_valid; post-reset req[2] granted first with ptr 0.
REQ-040 req[1] dropped in ISSUE cycle -> operation completes, rsp_valid[1] still pulses.
